// File: rtl/ped_request.sv
`default_nettype none
// ============================================================================
// Module   : ped_request
// Purpose  : Debounced pedestrian push-button to one-cycle pass request with
//            green-aware serving, hold-off cooldown and a grant counter.
// Revision : 1.0
// ============================================================================
module ped_request #(
    parameter int DEB_CYCLES = 4,
    parameter int HOLDOFF    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       G,
    output logic       pass,
    output logic       wait_lamp,
    output logic [7:0] grant_cnt
);

    localparam logic [3:0] C_DEB     = 4'(DEB_CYCLES);
    localparam logic [7:0] C_HOLDOFF = 8'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        PENDING       = 2'd1,
        COOLDOWN      = 2'd2,
        COOLDOWN_PEND = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, sync2_q;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [7:0] cd_q, cd_d;
    logic       pass_q, pass_d;
    logic       wait_q, wait_d;
    logic [7:0] grant_q, grant_d;

    logic       w_press;
    logic       w_pending;
    logic       w_pending_d;
    logic       w_cd_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= 4'd0;
            state_q   <= IDLE;
            cd_q      <= 8'd0;
            pass_q    <= 1'b0;
            wait_q    <= 1'b0;
            grant_q   <= 8'd0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            cd_q      <= cd_d;
            pass_q    <= pass_d;
            wait_q    <= wait_d;
            grant_q   <= grant_d;
        end
    end

    // Press fires once per held run: deb_cnt saturates and only clears on release.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (!sync2_q) begin
            deb_cnt_d = 4'd0;
        end else if (deb_cnt_q < C_DEB) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
        end
    end

    assign w_press   = sync2_q && (deb_cnt_q == (C_DEB - 4'd1));
    assign w_pending = (state_q == PENDING) || (state_q == COOLDOWN_PEND);
    assign w_cd_zero = (cd_q == 8'd0);

    always_comb begin
        w_pending_d = w_pending;
        cd_d        = w_cd_zero ? 8'd0 : (cd_q - 8'd1);
        pass_d      = 1'b0;
        grant_d     = grant_q;
        state_d     = state_q;

        // Issuing takes priority; a simultaneous press is absorbed into the pulse.
        if (w_pending && w_cd_zero && !G) begin
            pass_d      = 1'b1;
            w_pending_d = 1'b0;
            cd_d        = C_HOLDOFF;
            grant_d     = grant_q + 8'd1;
        end else if (w_pending && G) begin
            w_pending_d = 1'b0;
        end else if (w_press && !G) begin
            w_pending_d = 1'b1;
        end

        case ({w_pending_d, (cd_d != 8'd0)})
            2'b00:   state_d = IDLE;
            2'b10:   state_d = PENDING;
            2'b01:   state_d = COOLDOWN;
            default: state_d = COOLDOWN_PEND;
        endcase

        wait_d = w_pending_d;
    end

    assign pass      = pass_q;
    assign wait_lamp = wait_q;
    assign grant_cnt = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ped_request.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_request
// Purpose  : Self-checking bench for ped_request: directed table, hand-written
//            corner sequences and randomized traffic against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_ped_request;

    localparam int C_DEB     = 4;
    localparam int C_HOLDOFF = 20;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       G;
    logic       pass;
    logic       wait_lamp;
    logic [7:0] grant_cnt;

    int checks;
    int errors;

    ped_request #(.DEB_CYCLES(C_DEB), .HOLDOFF(C_HOLDOFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .G         (G),
        .pass      (pass),
        .wait_lamp (wait_lamp),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw button history, run length of synchronized highs,
    // and the edge number of the last pass (cooldown is elapsed time).
    bit m_hist[$];
    int m_run;
    bit m_pend;
    bit m_has_last;
    int m_last;
    int m_edge;
    int m_cnt;
    bit m_issue;

    typedef struct {
        logic btn;
        logic g;
        int   n;
        logic ep;
        logic ew;
        int   ec;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_run      = 0;
        m_pend     = 1'b0;
        m_has_last = 1'b0;
        m_last     = 0;
        m_edge     = 0;
        m_cnt      = 0;
        m_issue    = 1'b0;
    endtask

    task automatic model_edge(input bit b, input bit g);
        bit s2;
        bit press;
        bit ready;
        s2 = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
        m_hist.push_back(b);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_run   = s2 ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        press   = s2 && (m_run == C_DEB);
        m_edge++;
        ready   = !m_has_last || ((m_edge - m_last) > C_HOLDOFF);
        m_issue = 1'b0;
        if (m_pend && ready && !g) begin
            m_issue    = 1'b1;
            m_pend     = 1'b0;
            m_has_last = 1'b1;
            m_last     = m_edge;
            m_cnt      = (m_cnt + 1) % 256;
        end else if (m_pend && g) begin
            m_pend = 1'b0;
        end else if (press && !g) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(btn, G);
        #1;
        chk("model_pass", int'(pass), int'(m_issue));
        chk("model_wait", int'(wait_lamp), int'(m_pend));
        chk("model_cnt", int'(grant_cnt), m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_pass", int'(pass), 0);
        chk("rst_wait", int'(wait_lamp), 0);
        chk("rst_cnt", int'(grant_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic add(input logic b, input logic g, input int n,
                       input logic ep, input logic ew, input int ec);
        vec_t v;
        v.btn = b; v.g = g; v.n = n; v.ep = ep; v.ew = ew; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        int cyc;
        bit prev_pass;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        btn = 1'b0;
        G   = 1'b0;
        model_reset();

        // Edge-by-edge script from reset; expectations hold after the group's last edge.
        add(1, 0, 5, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 1);
        add(1, 0, 3, 0, 0, 1);
        add(0, 0, 2, 0, 0, 1);
        add(1, 0, 5, 0, 0, 1);
        add(1, 0, 1, 0, 1, 1);
        add(1, 0, 9, 0, 1, 1);
        add(1, 0, 1, 1, 0, 2);
        add(0, 0, 2, 0, 0, 2);
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 3, 0, 0, 2);
            add(0, 0, 1, 0, 0, 2);
        end
        add(0, 0, 4, 0, 0, 2);
        add(1, 1, 8, 0, 0, 2);
        add(0, 1, 3, 0, 0, 2);
        add(1, 0, 5, 0, 0, 2);
        add(1, 0, 1, 0, 1, 2);
        add(1, 1, 1, 0, 0, 2);
        add(1, 1, 5, 0, 0, 2);
        add(0, 0, 4, 0, 0, 2);

        do_reset();
        foreach (tbl[i]) begin
            btn = tbl[i].btn;
            G   = tbl[i].g;
            for (int c = 0; c < tbl[i].n; c++) step();
            chk($sformatf("tbl%0d_pass", i), int'(pass), int'(tbl[i].ep));
            chk($sformatf("tbl%0d_wait", i), int'(wait_lamp), int'(tbl[i].ew));
            chk($sformatf("tbl%0d_cnt", i), int'(grant_cnt), tbl[i].ec);
        end

        // Reset while a request waits out the cooldown.
        btn = 1'b0; G = 1'b0;
        do_reset();
        btn = 1'b1;
        for (int c = 0; c < 7; c++) step();
        chk("cp_first_pass", int'(pass), 1);
        btn = 1'b0;
        for (int c = 0; c < 2; c++) step();
        btn = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("cp_wait", int'(wait_lamp), 1);
        chk("cp_cnt", int'(grant_cnt), 1);
        btn = 1'b0;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            step();
            chk("post_rst_pass", int'(pass), 0);
        end

        // Wrap the grant counter with repeated presses.
        do_reset();
        pulses = 0;
        cyc = 0;
        prev_pass = 1'b0;
        while (pulses < 256 && cyc < 20000) begin
            btn = ((cyc % 11) < 8);
            G   = 1'b0;
            step();
            if (pass) begin
                pulses++;
                chk("pulse_width", int'(prev_pass), 0);
            end
            prev_pass = pass;
            cyc++;
        end
        chk("wrap_pulses", pulses, 256);
        chk("wrap_cnt", int'(grant_cnt), 0);

        // Randomized traffic with occasional reset.
        btn = 1'b0;
        G   = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) btn = ~btn;
            if ($urandom_range(0, 19) == 0) G = ~G;
            if ((i % 997) == 500) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
